// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/up/down buttons walk a field-select FSM
// and raise inc/dec requests that are retired by the next 1 Hz rising edge.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic clk_1hz,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  output logic set_sec,
  output logic set_min,
  output logic set_hour,
  output logic set_day,
  output logic set_month,
  output logic set_year,
  output logic inc,
  output logic dec
);

  // state     | meaning
  // RUN       | normal timekeeping, no field selected
  // SET_SEC   | seconds field selected
  // SET_MIN   | minutes field selected
  // SET_HOUR  | hours field selected
  // SET_DAY   | day field selected
  // SET_MONTH | month field selected
  // SET_YEAR  | year field selected
  typedef enum logic [2:0] {
    RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MONTH, SET_YEAR
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_S + 1);

  // bit order everywhere: {clk_1hz, down, up, mode}
  logic [3:0]          sync1, sync2;
  logic [2:0]          db, db_d;
  logic [2:0][DBW-1:0] db_cnt;
  logic                hz_d;
  logic [2:0]          press;
  logic                tick;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hz_d  <= 1'b0;
      db    <= '0;
      db_d  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {clk_1hz, btn_down, btn_up, btn_mode};
      sync2 <= sync1;
      hz_d  <= sync2[3];
      db_d  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_d;
  assign tick  = sync2[3] & ~hz_d;

  state_t         state, state_nxt;
  logic           inc_nxt, dec_nxt;
  logic [TOW-1:0] to_cnt, to_nxt;
  logic           pending, any_press, mode_p, up_p, dn_p;

  assign pending   = inc | dec;
  assign any_press = |press;
  assign mode_p    = press[0];
  // mode wins over up/down so the field never changes together with a new request
  assign up_p      = press[1] & ~press[2] & ~press[0];
  assign dn_p      = press[2] & ~press[1] & ~press[0];

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      inc    <= 1'b0;
      dec    <= 1'b0;
      to_cnt <= '0;
      {set_year, set_month, set_day, set_hour, set_min, set_sec} <= '0;
    end else begin
      state  <= state_nxt;
      inc    <= inc_nxt;
      dec    <= dec_nxt;
      to_cnt <= to_nxt;
      set_sec   <= (state_nxt == SET_SEC);
      set_min   <= (state_nxt == SET_MIN);
      set_hour  <= (state_nxt == SET_HOUR);
      set_day   <= (state_nxt == SET_DAY);
      set_month <= (state_nxt == SET_MONTH);
      set_year  <= (state_nxt == SET_YEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    inc_nxt   = inc;
    dec_nxt   = dec;
    to_nxt    = to_cnt;
    if (pending && tick) begin
      inc_nxt = 1'b0;
      dec_nxt = 1'b0;
    end
    if (state == RUN) begin
      if (mode_p) state_nxt = SET_SEC;
    end else begin
      if (any_press)
        to_nxt = '0;
      else if (tick && to_cnt != TOW'(TIMEOUT_S))
        to_nxt = to_cnt + 1'b1;
      if (!pending) begin
        if (mode_p) begin
          case (state)
            SET_SEC:   state_nxt = SET_MIN;
            SET_MIN:   state_nxt = SET_HOUR;
            SET_HOUR:  state_nxt = SET_DAY;
            SET_DAY:   state_nxt = SET_MONTH;
            SET_MONTH: state_nxt = SET_YEAR;
            default:   state_nxt = RUN;
          endcase
        end else if (up_p) begin
          inc_nxt = 1'b1;
        end else if (dn_p) begin
          dec_nxt = 1'b1;
        end else if (!any_press && to_cnt == TOW'(TIMEOUT_S)) begin
          state_nxt = RUN;
        end
      end
    end
    if (state_nxt != state) to_nxt = '0;
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button/1 Hz activity
// compared against an abstract field/request model.
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst, clk_1hz, btn_mode, btn_up, btn_down;
  logic set_sec, set_min, set_hour, set_day, set_month, set_year, inc, dec;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
    .clk_50MHz(clk), .rst(rst), .clk_1hz(clk_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .inc(inc), .dec(dec)
  );

  always #10 clk = ~clk;

  int nvec = 0, nfail = 0;
  // model: field index 0=RUN..6=year, pending 0/1=inc/2=dec, idle ticks, request count
  int m_idx = 0, m_pend = 0, m_to = 0, m_reqs = 0, seen_reqs = 0;
  logic prev_req = 1'b0;

  wire [5:0] set_vec = {set_year, set_month, set_day, set_hour, set_min, set_sec};

  always @(negedge clk) begin
    if ((inc | dec) && !prev_req) seen_reqs++;
    prev_req = inc | dec;
    assert (!(inc && dec)) else begin
      nfail++;
      $error("FAIL inc_dec_excl observed=%0b%0b expected=not both", inc, dec);
    end
    assert ($countones(set_vec) <= 1) else begin
      nfail++;
      $error("FAIL set_onehot observed=%b expected=at most one", set_vec);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [7:0] exp_set;
    exp_set = (m_idx == 0) ? 8'h00 : 8'(1 << (m_idx - 1));
    chk({tag, "_set"}, {2'b00, set_vec}, exp_set);
    chk({tag, "_inc"}, {7'd0, inc}, {7'd0, m_pend == 1});
    chk({tag, "_dec"}, {7'd0, dec}, {7'd0, m_pend == 2});
  endtask

  // which: 0 mode, 1 up, 2 down, 3 up+down together
  task automatic press(input int which, input int hold);
    btn_mode = (which == 0);
    btn_up   = (which == 1) || (which == 3);
    btn_down = (which == 2) || (which == 3);
    cyc(hold);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(14);
    if (hold >= 4) begin
      if (m_idx != 0) m_to = 0;
      if (which == 0 && m_pend == 0) begin
        m_idx = (m_idx + 1) % 7;
        m_to  = 0;
      end else if ((which == 1 || which == 2) && m_idx != 0 && m_pend == 0) begin
        m_pend = which;
        m_reqs++;
      end
    end
  endtask

  task automatic model_tick();
    m_pend = 0;
    if (m_idx != 0) begin
      if (m_to < 3) m_to++;
      if (m_to >= 3) begin
        m_idx = 0;
        m_to  = 0;
      end
    end
  endtask

  task automatic pulse_1hz();
    clk_1hz = 1'b1;
    cyc(8);
    clk_1hz = 1'b0;
    cyc(8);
    model_tick();
  endtask

  initial begin
    rst = 1'b1; clk_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(3);
    chk_state("reset");
    rst = 1'b0;
    cyc(3);

    for (int i = 0; i < 7; i++) begin
      press(0, 8);
      chk_state($sformatf("mode%0d", i + 1));
    end

    press(0, 8); press(0, 8);
    chk_state("to_min");
    press(1, 3);
    chk_state("glitch");
    press(1, 8);
    chk_state("up_req");
    press(1, 8);
    chk_state("up_drop");
    press(0, 8);
    chk_state("mode_drop");
    clk_1hz = 1'b1;
    cyc(2);
    chk("inc_hold", {7'd0, inc}, 8'd1);
    cyc(1);
    chk("inc_done", {7'd0, inc}, 8'd0);
    cyc(5);
    clk_1hz = 1'b0;
    cyc(8);
    model_tick();
    chk_state("after_tick");
    chk("single_req", 8'(seen_reqs), 8'(m_reqs));

    press(0, 8);
    press(3, 8);
    chk_state("both_hour");

    press(0, 8);
    pulse_1hz(); pulse_1hz();
    chk_state("day_2ticks");
    pulse_1hz();
    chk_state("day_timeout");

    for (int i = 0; i < 4; i++) press(0, 8);
    pulse_1hz(); pulse_1hz();
    press(3, 8);
    pulse_1hz(); pulse_1hz();
    chk_state("day_restart");
    pulse_1hz();
    chk_state("day_timeout2");

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op == 5) pulse_1hz();
      else if (op == 4) press(0, 8);
      else press(op, $urandom_range(2, 9));
      chk_state($sformatf("rnd%0d", i));
    end
    chk("req_count", 8'(seen_reqs), 8'(m_reqs));

    for (int i = 0; i < 40 && m_idx != 6; i++) begin
      if (m_pend != 0) pulse_1hz();
      else press(0, 8);
    end
    press(2, 8);
    chk_state("year_dec");
    rst = 1'b1;
    #1;
    chk("rst_dec", {7'd0, dec}, 8'd0);
    chk("rst_year", {7'd0, set_year}, 8'd0);
    m_idx = 0; m_pend = 0; m_to = 0;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    chk_state("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the consecutive stable clk_50MHz cycles needed to accept a button level (20 ms).
REQ-002 SHALL have parameter TIMEOUT_S, default 30, the whole clk_1hz periods without a press before auto-exit to RUN.
REQ-003 SHALL have port clk_50MHz  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_1hz  input  1  the clock/calendar's 1 Hz clock, sampled as data only.
REQ-006 SHALL have port btn_mode  input  1  raw asynchronous mode button, active-high.
REQ-007 SHALL have port btn_up  input  1  raw asynchronous increment button, active-high.
REQ-008 SHALL have port btn_down  input  1  raw asynchronous decrement button, active-high.
REQ-009 SHALL have port set_sec  output  1  seconds field selected for setting.
REQ-010 SHALL have port set_min  output  1  minutes field selected.
REQ-011 SHALL have port set_hour  output  1  hours field selected.
REQ-012 SHALL have port set_day  output  1  day field selected.
REQ-013 SHALL have port set_month  output  1  month field selected.
REQ-014 SHALL have port set_year  output  1  year field selected.
REQ-015 SHALL have port inc  output  1  increment request to the counter chain, held per REQ-024.
REQ-016 SHALL have port dec  output  1  decrement request to the counter chain, held per REQ-024.

Function
REQ-017 SHALL pass btn_mode, btn_up, btn_down and clk_1hz each through a 2-flop synchronizer before any use.
REQ-018 SHALL change each debounced button level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that button's count.
REQ-019 SHALL generate a one-cycle press event on each debounced 0->1 transition; releases generate nothing.
REQ-020 SHALL implement FSM states RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MONTH, SET_YEAR; a mode press advances in that order, SET_YEAR -> RUN.
REQ-021 SHALL drive set_* as registered one-hot decode of the state, all low in RUN; at most one set_* high in any cycle.
REQ-022 SHALL ignore up/down presses in RUN.
REQ-023 SHALL, in a SET state with no request pending, assert inc on an up press (dec on a down press) in the next cycle.
REQ-024 SHALL hold inc/dec high until a rising edge of synchronized clk_1hz is detected, then deassert in the following cycle (request complete).
REQ-025 SHALL drop up/down presses arriving while a request is pending; inc and dec are never high together.
REQ-026 SHALL ignore up and down presses occurring in the same cycle.
REQ-027 SHALL ignore mode presses while a request is pending, so set_* never changes while inc/dec is high.
REQ-028 SHALL count synchronized clk_1hz rising edges in any SET state, clear the count on any press event, and move to RUN when it reaches TIMEOUT_S, deferred until any pending request completes.
REQ-029 SHALL clear the timeout count on every state change.

Reset
REQ-030 SHALL, while rst is high, force state RUN, all set_* = 0, inc = dec = 0, synchronizers, debounced levels and counters to 0, asynchronously.
REQ-031 SHALL, on reset mid-request, drop the request; no inc/dec after rst falls without a new press.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_S=3)
REQ-032 SHALL verify 5 mode presses from RUN -> set_sec, set_min, set_hour, set_day, set_month high in turn; a 6th -> set_year, a 7th -> RUN, all set_* 0.
REQ-033 SHALL verify btn_up glitch of 3 cycles -> no state or inc change; held 4+ cycles in SET_MIN -> inc high until the cycle after the next clk_1hz rise, exactly one request.
REQ-034 SHALL verify second up press and a mode press during a pending inc -> both dropped; state unchanged, single inc pulse.
REQ-035 SHALL verify up and down pressed the same cycle in SET_HOUR -> inc = dec = 0.
REQ-036 SHALL verify SET_DAY with no presses for 3 clk_1hz rises -> RUN after the 3rd; a press after the 2nd rise restarts the count.
REQ-037 SHALL verify rst pulsed while dec is held -> dec and set_year low at once, state RUN after release.
